toggle_bank_scheduler: RTL and testbench

- Shares one toggle-update slot among N pulse requesters, such as debounced lab push-buttons, by round-robin arbitration.
- Each granted request flips that channel's latched toggle bit, the same pulse-to-level behaviour as a single pulse-to-toggle FSM.
- After every service a programmable lockout period blocks further grants, so downstream logic sees at most one toggle edge per HOLD+1 cycles.
- Sits between button conditioning and the LED/control outputs.

---
 rtl/toggle_bank_scheduler.sv | 138 +++++++++++++
 tb/tb_toggle_bank_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_bank_scheduler.sv
// toggle_bank_scheduler: round-robin arbiter that shares one toggle-update
// slot among N pulse requesters. Each serviced request flips that channel's
// toggle bit, then a HOLD-cycle lockout blocks further grants.
module toggle_bank_scheduler #(
  parameter int N    = 4,
  parameter int HOLD = 3,
  parameter int CW   = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         clear,
  output logic [N-1:0] toggles,
  output logic [N-1:0] grant,
  output logic         busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE_N = N'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t         state_q,   state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   toggles_q, toggles_d;
  logic [N-1:0]   grant_q,   grant_d;
  logic [PW-1:0]  ptr_q,     ptr_d;
  logic [PW-1:0]  idx_q,     idx_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic           busy_q,    busy_d;

  logic [PW-1:0]  rr_idx;
  logic           rr_found;
  logic [PW-1:0]  rr_cand;

  // Round-robin search: first pending channel after the last one serviced.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      rr_cand = PW'((int'(ptr_q) + k) % N);
      if (!rr_found && pending_q[rr_cand]) begin
        rr_idx   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // Next-state, pending latch, toggle flip and registered output decode.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    toggles_d = toggles_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    busy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          idx_d   = rr_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // grant_q is one-hot on idx_q here; a same-cycle re-request survives.
        toggles_d = toggles_q ^ grant_q;
        pending_d = (pending_q & ~grant_q) | req;
        ptr_d     = idx_q;
        if (HOLD == 0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CW'(HOLD);
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear wipes toggles and pending, aborts any grant, keeps the pointer.
    if (clear) begin
      state_d   = IDLE;
      pending_d = '0;
      toggles_d = '0;
      cnt_d     = '0;
      ptr_d     = ptr_q;
    end

    // Outputs are registered: decode them from the state being entered.
    if (state_d == GRANT) begin
      grant_d = ONE_N << idx_d;
    end
    busy_d = (state_d != IDLE);
  end

  // State register; reset restores ptr=N-1 so channel 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      toggles_q <= '0;
      grant_q   <= '0;
      ptr_q     <= PW'(N - 1);
      idx_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      toggles_q <= toggles_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign toggles = toggles_q;
  assign grant   = grant_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_toggle_bank_scheduler.sv
// Testbench for toggle_bank_scheduler: two builds (HOLD=3 and HOLD=0) share
// stimulus; a timestamp-based model predicts every output each cycle, and
// directed scenarios pin specific literal values.
module tb_toggle_bank_scheduler;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] tog0, gr0, tog1, gr1;
  logic         busy0, busy1;

  always #5 clock = ~clock;

  toggle_bank_scheduler #(.N(N), .HOLD(3), .CW(4)) dut0 (
    .clock(clock), .reset(reset), .req(req), .clear(clear),
    .toggles(tog0), .grant(gr0), .busy(busy0)
  );

  toggle_bank_scheduler #(.N(N), .HOLD(0), .CW(4)) dut1 (
    .clock(clock), .reset(reset), .req(req), .clear(clear),
    .toggles(tog1), .grant(gr1), .busy(busy1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit model_valid = 1'b0;

  // Model: pending set, toggle word, pointer, and timestamps of the
  // scheduled grant and of the earliest cycle a new decision may be made.
  logic [N-1:0] m_pend [2];
  logic [N-1:0] m_tog  [2];
  int           m_ptr  [2];
  int           m_gcyc [2];
  int           m_gidx [2];
  int           m_next [2];
  int           hold_of [2];

  function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant(input int m);
    logic [N-1:0] r;
    r = '0;
    if (m_gcyc[m] == cyc) r[m_gidx[m]] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_busy(input int m);
    return (cyc >= m_gcyc[m]) && (cyc < m_next[m]);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Advance the model over cycle 'cyc' using the inputs sampled at its end.
  task automatic model_step();
    logic [N-1:0] old;
    int pick;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_pend[m] = '0;
        m_tog[m]  = '0;
        m_ptr[m]  = N - 1;
        m_gcyc[m] = -100;
        m_next[m] = cyc + 1;
      end else if (clear) begin
        m_pend[m] = '0;
        m_tog[m]  = '0;
        m_gcyc[m] = -100;
        m_next[m] = cyc + 1;
      end else begin
        old = m_pend[m];
        if (cyc == m_gcyc[m]) begin
          m_tog[m][m_gidx[m]]  = ~m_tog[m][m_gidx[m]];
          m_pend[m][m_gidx[m]] = 1'b0;
          m_ptr[m]             = m_gidx[m];
        end
        if (cyc >= m_next[m] && old != '0) begin
          pick      = rr_pick(old, m_ptr[m]);
          m_gidx[m] = pick;
          m_gcyc[m] = cyc + 1;
          m_next[m] = cyc + 2 + hold_of[m];
        end
        m_pend[m] = m_pend[m] | req;
      end
    end
    if (reset) model_valid = 1'b1;
  endtask

  // One clock: model update at the edge, full output comparison mid-cycle.
  task automatic tick();
    @(posedge clock);
    model_step();
    cyc++;
    @(negedge clock);
    if (model_valid) begin
      check("m_grant0",   8'(gr0),   8'(exp_grant(0)));
      check("m_toggles0", 8'(tog0),  8'(m_tog[0]));
      check("m_busy0",    8'(busy0), 8'(exp_busy(0)));
      check("m_grant1",   8'(gr1),   8'(exp_grant(1)));
      check("m_toggles1", 8'(tog1),  8'(m_tog[1]));
      check("m_busy1",    8'(busy1), 8'(exp_busy(1)));
      if (gr0 != '0)
        $display("[TB] cyc %0d dut0 grant=%b toggles=%b", cyc, gr0, tog0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; req = '0;
    tick();
    reset = 1'b0;
  endtask

  logic [N-1:0] exp_f;

  initial begin
    hold_of[0] = 3;
    hold_of[1] = 0;
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0; m_tog[m] = '0; m_ptr[m] = N - 1;
      m_gcyc[m] = -100; m_gidx[m] = 0; m_next[m] = 0;
    end

    // Reset state.
    tick();
    do_reset();
    check("rst_toggles", 8'(tog0), 8'b0000);
    check("rst_grant",   8'(gr0),  8'b0000);
    check("rst_busy",    8'(busy0), 8'b0);

    // Single pulse on channel 0.
    req = 4'b0001; tick(); req = '0;          // now t+1
    check("sp_grant_t1", 8'(gr0), 8'b0000);
    tick();                                   // t+2
    check("sp_grant_t2", 8'(gr0), 8'b0001);
    check("sp_busy_t2",  8'(busy0), 8'b1);
    tick();                                   // t+3
    check("sp_toggles_t3", 8'(tog0), 8'b0001);
    check("sp_h0_busy_t3", 8'(busy1), 8'b0);
    ticks(2);                                 // t+5
    check("sp_busy_t5", 8'(busy0), 8'b1);
    tick();                                   // t+6
    check("sp_busy_t6", 8'(busy0), 8'b0);
    req = 4'b0001; tick(); req = '0;
    ticks(2);
    check("sp_toggles_back", 8'(tog0), 8'b0000);
    ticks(6);

    // Simultaneous requests from reset: 0,1,2,3 spaced HOLD+2=5 apart.
    do_reset();
    req = 4'b1111; tick(); req = '0;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (k >= 2 && k <= 17 && (k - 2) % 5 == 0)
        check("sim_grant_order", 8'(gr0), 8'(4'b0001 << ((k - 2) / 5)));
    end
    check("sim_final_toggles", 8'(tog0), 8'b1111);

    // Fairness: channels 0 and 2 held high must alternate.
    do_reset();
    exp_f = 4'b0001;
    req = 4'b0101;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (gr0 != '0) begin
        check("fair_alternate", 8'(gr0), 8'(exp_f));
        exp_f = (exp_f == 4'b0001) ? 4'b0100 : 4'b0001;
      end
    end
    req = '0;
    ticks(15);

    // Re-request in own grant cycle keeps channel 1 pending.
    do_reset();
    req = 4'b0010; tick(); req = '0;          // t+1
    tick();                                   // t+2
    check("rr_grant_first", 8'(gr0), 8'b0010);
    req = 4'b0010; tick(); req = '0;          // t+3
    check("rr_toggles_set", 8'(tog0), 8'b0010);
    ticks(4);                                 // t+7
    check("rr_grant_again", 8'(gr0), 8'b0010);
    tick();                                   // t+8
    check("rr_toggles_back", 8'(tog0), 8'b0000);
    ticks(6);

    // Clear during cooldown, then the same with reset.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      req = 4'b0101; tick(); req = '0;        // t+1
      ticks(6);                               // t+7
      check("cc_grant_ch2", 8'(gr0), 8'b0100);
      tick();                                 // t+8
      check("cc_toggles", 8'(tog0), 8'b0101);
      req = 4'b0010; tick(); req = '0;        // t+9, cooldown, pending 0010
      if (pass == 0) clear = 1'b1; else reset = 1'b1;
      tick();                                 // t+10
      clear = 1'b0; reset = 1'b0;
      check("cc_toggles_zero", 8'(tog0), 8'b0000);
      check("cc_busy_zero",    8'(busy0), 8'b0);
      check("cc_grant_zero",   8'(gr0),  8'b0000);
      for (int k = 0; k < 8; k++) begin
        tick();
        check("cc_no_grant", 8'(gr0), 8'b0000);
      end
    end

    // After reset channel 0 wins a tie; HOLD=0 build grants two cycles apart.
    req = 4'b0011; tick(); req = '0;          // t+1
    tick();                                   // t+2
    check("tie_grant_ch0",   8'(gr0), 8'b0001);
    check("h0_grant_first",  8'(gr1), 8'b0001);
    tick();                                   // t+3
    check("h0_idle_busy",    8'(busy1), 8'b0);
    check("h0_idle_grant",   8'(gr1), 8'b0000);
    tick();                                   // t+4
    check("h0_grant_second", 8'(gr1), 8'b0010);
    ticks(10);

    // Randomized traffic with occasional clear and reset.
    for (int k = 0; k < 1500; k++) begin
      req   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      clear = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    req = '0; clear = 1'b0; reset = 1'b0;
    ticks(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
